nios2_oci_trace_capture: RTL and testbench
==========================================

NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: nios2_oci_trace_capture

Interface
REQ-001 SHALL have parameter DCT_W, default 30, trace word width.
REQ-002 SHALL have parameter CNT_W, default 4, frame slot-count width.
REQ-003 SHALL have parameter DEPTH, default 16, power of two >= 2, FIFO entries.
REQ-004 SHALL have parameter WRAP, default 0; 0 = stop-on-full, 1 = overwrite-oldest.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port dct_buffer  in  DCT_W  trace frame payload.
REQ-009 SHALL have port dct_count  in  CNT_W  valid slots in frame; 0 = empty frame.
REQ-010 SHALL have port dct_valid  in  1  frame strobe, one cycle per frame.
REQ-011 SHALL have port arm  in  1  start or restart capture.
REQ-012 SHALL have port test_ending  in  1  stop accepting frames.
REQ-013 SHALL have port test_has_ended  in  1  test finished; allows DONE.
REQ-014 SHALL have port rd_ready  in  1  consumer accepts head entry.
REQ-015 SHALL have port rd_valid  out  1  head entry available.
REQ-016 SHALL have port rd_data  out  CNT_W+DCT_W  {dct_count, dct_buffer} of head entry.
REQ-017 SHALL have port fill_level  out  clog2(DEPTH)+1  entries held.
REQ-018 SHALL have port overflow  out  1  sticky; a frame was dropped or overwritten.
REQ-019 SHALL have port drop_count  out  16  frames lost; saturates at 0xFFFF.
REQ-020 SHALL have port state  out  2  IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.

Function
REQ-021 SHALL implement states IDLE, CAPTURE, DRAIN, DONE.
REQ-022 IDLE->CAPTURE on arm; IDLE ignores test_ending and test_has_ended.
REQ-023 CAPTURE->DRAIN on test_ending or test_has_ended; arm ignored in CAPTURE.
REQ-024 DRAIN->DONE when fill_level==0 and test_has_ended (same or later cycle).
REQ-025 DONE->CAPTURE on arm, clearing FIFO, overflow and drop_count in that cycle.
REQ-026 Frame SHALL be a write candidate only in CAPTURE with dct_valid=1 and dct_count!=0; others ignored, not counted.
REQ-027 Candidate SHALL be written if not full, or if full and rd_valid&rd_ready in the same cycle.
REQ-028 WRAP=0, full, no read: frame dropped, drop_count+1, overflow set.
REQ-029 WRAP=1, full, no read: oldest entry discarded, frame written, fill_level unchanged, drop_count+1, overflow set.
REQ-030 rd_valid SHALL equal fill_level!=0 in CAPTURE, DRAIN, DONE; 0 in IDLE.
REQ-031 First-word-fall-through: frame written at edge N SHALL appear on rd_data with rd_valid after edge N.
REQ-032 rd_data SHALL stay stable while rd_valid=1 and rd_ready=0, except head overwrite under REQ-029.
REQ-033 Pointers SHALL wrap modulo DEPTH; fill_level SHALL reach exactly DEPTH when full.
REQ-034 drop_count SHALL hold at 0xFFFF; overflow cleared only by reset or REQ-025.

Reset
REQ-035 On reset_n=0, asynchronously: state=IDLE, pointers and fill_level=0, rd_valid=0, overflow=0, drop_count=0.
REQ-036 rd_data SHALL be 0 after reset; storage contents need not be reset.
REQ-037 Reset mid-capture SHALL discard all entries; no partial write survives.

Structure
REQ-038 Shared package nios2_oci_trace_pkg SHALL hold the state enum and encodings, default parameter values, and drop-counter width.
REQ-039 Storage and pointers SHALL be sub-module nios2_oci_trace_fifo (parameters DATA_W, DEPTH, WRAP); FSM and counters in the top.

Verification (DEPTH=4)
REQ-040 Reset, arm, 3 frames count=2 buffer=0x1,0x2,0x3 -> fill_level=3; reads return {2,0x1},{2,0x2},{2,0x3} in order.
REQ-041 WRAP=0, 6 frames 0x10..0x15, no reads -> fill_level=4, drop_count=2, overflow=1, reads 0x10..0x13.
REQ-042 WRAP=1, same stimulus -> fill_level=4, drop_count=2, overflow=1, reads 0x12..0x15.
REQ-043 Full, write with rd_ready=1 same cycle -> no drop, fill_level stays 4, drop_count unchanged.
REQ-044 test_ending with 2 entries, test_has_ended high -> state DRAIN until 2nd read, then DONE; frames with count=0 never written.
REQ-045 reset_n low mid-CAPTURE with 3 entries -> state=IDLE, fill_level=0, rd_valid=0 without a clock edge.

Source files
------------

// File: rtl/nios2_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_trace_pkg
// Description : Shared capture-state encodings and default sizing for the
//               OCI trace capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int c_dct_w_def = 30;
    localparam int c_cnt_w_def = 4;
    localparam int c_depth_def = 16;
    localparam int c_wrap_def  = 0;
    localparam int c_drop_w    = 16;

endpackage
`default_nettype wire

// File: rtl/nios2_oci_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_trace_fifo
// Description : First-word-fall-through trace FIFO with optional
//               overwrite-oldest behaviour when full.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_oci_trace_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       empty,
    output logic                       lost
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);
    localparam bit            c_wrap  = (WRAP != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_read;
    logic w_lost;
    logic w_overwrite;
    logic w_do_write;
    logic w_inc;

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_do_read   = rd_en & ~w_empty;
    // A write into a full FIFO is only safe when the head leaves this cycle.
    assign w_lost      = wr_en & w_full & ~w_do_read;
    assign w_overwrite = w_lost & c_wrap;
    assign w_do_write  = wr_en & ~clear & (~w_lost | c_wrap);
    assign w_inc       = w_do_write & ~w_overwrite;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Overwriting the head retires it, so the read pointer follows.
            if (w_do_read || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_inc && !w_do_read) begin
                r_count <= r_count + 1'b1;
            end else if (!w_inc && w_do_read) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fill_level = r_count;
    assign empty      = w_empty;
    assign lost       = w_lost & ~clear;

endmodule
`default_nettype wire

// File: rtl/nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_trace_capture
// Description : Captures non-empty trace frames into a FIFO under control of
//               an IDLE/CAPTURE/DRAIN/DONE sequencer, tracking lost frames.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int DCT_W = c_dct_w_def,
    parameter int CNT_W = c_cnt_w_def,
    parameter int DEPTH = c_depth_def,
    parameter int WRAP  = c_wrap_def
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DCT_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     dct_valid,
    input  logic                     arm,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W+DCT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [c_drop_w-1:0]      drop_count,
    output logic [1:0]               state
);

    trace_state_e              r_state;
    logic                      r_overflow;
    logic [c_drop_w-1:0]       r_drop_count;

    logic [CNT_W+DCT_W-1:0]    w_head;
    logic [$clog2(DEPTH):0]    w_fill;
    logic                      w_empty;
    logic                      w_lost;
    logic                      w_cand;
    logic                      w_clear;
    logic                      w_rd_en;

    assign w_cand  = (r_state == ST_CAPTURE) & dct_valid & (dct_count != '0);
    assign w_clear = (r_state == ST_DONE) & arm;
    assign rd_valid = (r_state != ST_IDLE) & ~w_empty;
    assign w_rd_en  = rd_valid & rd_ready;

    nios2_oci_trace_fifo #(
        .DATA_W (CNT_W + DCT_W),
        .DEPTH  (DEPTH),
        .WRAP   (WRAP)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (w_clear),
        .wr_en      (w_cand),
        .wr_data    ({dct_count, dct_buffer}),
        .rd_en      (w_rd_en),
        .rd_data    (w_head),
        .fill_level (w_fill),
        .empty      (w_empty),
        .lost       (w_lost)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (test_ending || test_has_ended) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((w_fill == '0) && test_has_ended) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (arm) r_state <= ST_CAPTURE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_lost) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign rd_data    = rd_valid ? w_head : '0;
    assign fill_level = w_fill;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_oci_trace_capture
// Description : Directed bench driving a stop-on-full and a wrapping instance
//               (DEPTH=4) with the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_oci_trace_capture;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [DCT_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             dct_valid;
    logic             arm;
    logic             test_ending;
    logic             test_has_ended;
    logic             rd_ready;

    logic                   rd_valid_a, rd_valid_b;
    logic [CNT_W+DCT_W-1:0] rd_data_a, rd_data_b;
    logic [2:0]             fill_a, fill_b;
    logic                   ovf_a, ovf_b;
    logic [15:0]            drop_a, drop_b;
    logic [1:0]             state_a, state_b;

    int checks = 0;
    int errors = 0;

    logic [29:0] exp_a [4];
    logic [29:0] exp_b [4];

    always #5 clk = ~clk;

    nios2_oci_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP(0)) u_dut_stop (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .arm(arm), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(rd_valid_a),
        .rd_data(rd_data_a), .fill_level(fill_a), .overflow(ovf_a),
        .drop_count(drop_a), .state(state_a)
    );

    nios2_oci_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP(1)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .arm(arm), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(rd_valid_b),
        .rd_data(rd_data_b), .fill_level(fill_b), .overflow(ovf_b),
        .drop_count(drop_b), .state(state_b)
    );

    function automatic logic [33:0] mk(input logic [3:0] cnt, input logic [29:0] buf_v);
        return {cnt, buf_v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_valid = 1'b0;
        arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        exp_a = '{30'h11, 30'h12, 30'h13, 30'h16};
        exp_b = '{30'h13, 30'h14, 30'h15, 30'h16};

        tick(); tick();
        chk("rst_state_a", 64'(state_a), 64'd0);
        chk("rst_fill_a", 64'(fill_a), 64'd0);
        chk("rst_rdvalid_a", 64'(rd_valid_a), 64'd0);
        chk("rst_rddata_a", 64'(rd_data_a), 64'd0);
        chk("rst_ovf_b", 64'(ovf_b), 64'd0);
        chk("rst_drop_b", 64'(drop_b), 64'd0);
        reset_n = 1'b1;

        // IDLE ignores test_ending
        test_ending = 1'b1; tick(); test_ending = 1'b0;
        chk("idle_hold", 64'(state_a), 64'd0);

        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_state_a", 64'(state_a), 64'd1);
        chk("arm_state_b", 64'(state_b), 64'd1);

        for (int i = 1; i <= 3; i++) begin
            dct_valid = 1'b1; dct_count = 4'd2; dct_buffer = 30'(i); tick();
        end
        dct_count = 4'd0; dct_buffer = 30'h3ff; tick();
        dct_valid = 1'b0;
        chk("three_fill_a", 64'(fill_a), 64'd3);
        chk("three_fill_b", 64'(fill_b), 64'd3);
        chk("three_rdvalid", 64'(rd_valid_a), 64'd1);

        rd_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("order_a", 64'(rd_data_a), 64'(mk(4'd2, 30'(i))));
            chk("order_b", 64'(rd_data_b), 64'(mk(4'd2, 30'(i))));
            tick();
        end
        rd_ready = 1'b0;
        chk("empty_fill", 64'(fill_a), 64'd0);
        chk("empty_rdvalid", 64'(rd_valid_a), 64'd0);

        for (int i = 0; i < 6; i++) begin
            dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h10 + 30'(i); tick();
        end
        dct_valid = 1'b0;
        chk("full_fill_a", 64'(fill_a), 64'd4);
        chk("full_fill_b", 64'(fill_b), 64'd4);
        chk("full_drop_a", 64'(drop_a), 64'd2);
        chk("full_drop_b", 64'(drop_b), 64'd2);
        chk("full_ovf_a", 64'(ovf_a), 64'd1);
        chk("full_ovf_b", 64'(ovf_b), 64'd1);
        chk("head_a", 64'(rd_data_a), 64'(mk(4'd1, 30'h10)));
        chk("head_b", 64'(rd_data_b), 64'(mk(4'd1, 30'h12)));
        tick();
        chk("head_stable_a", 64'(rd_data_a), 64'(mk(4'd1, 30'h10)));

        dct_valid = 1'b1; dct_buffer = 30'h16; rd_ready = 1'b1; tick();
        dct_valid = 1'b0; rd_ready = 1'b0;
        chk("rw_fill_a", 64'(fill_a), 64'd4);
        chk("rw_fill_b", 64'(fill_b), 64'd4);
        chk("rw_drop_a", 64'(drop_a), 64'd2);
        chk("rw_drop_b", 64'(drop_b), 64'd2);

        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_a", 64'(rd_data_a), 64'(mk(4'd1, exp_a[i])));
            chk("drain_b", 64'(rd_data_b), 64'(mk(4'd1, exp_b[i])));
            tick();
        end
        rd_ready = 1'b0;
        chk("ovf_sticky", 64'(ovf_a), 64'd1);

        dct_valid = 1'b1; dct_count = 4'd3; dct_buffer = 30'h20; tick();
        dct_buffer = 30'h21; tick();
        dct_count = 4'd0; dct_buffer = 30'h22; tick();
        dct_valid = 1'b0;
        chk("cnt0_fill", 64'(fill_a), 64'd2);

        test_ending = 1'b1; test_has_ended = 1'b1; tick(); test_ending = 1'b0;
        chk("drain_state", 64'(state_a), 64'd2);
        dct_valid = 1'b1; dct_count = 4'd1; tick(); dct_valid = 1'b0;
        chk("drain_hold", 64'(state_a), 64'd2);
        chk("drain_nowrite", 64'(fill_a), 64'd2);
        rd_ready = 1'b1;
        chk("drain_head", 64'(rd_data_a), 64'(mk(4'd3, 30'h20)));
        tick();
        chk("drain_rd1_state", 64'(state_a), 64'd2);
        chk("drain_rd1_fill", 64'(fill_a), 64'd1);
        tick(); rd_ready = 1'b0;
        chk("drain_rd2_fill", 64'(fill_a), 64'd0);
        tick();
        chk("done_state_a", 64'(state_a), 64'd3);
        chk("done_state_b", 64'(state_b), 64'd3);
        test_has_ended = 1'b0;

        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_state", 64'(state_a), 64'd1);
        chk("rearm_ovf", 64'(ovf_a), 64'd0);
        chk("rearm_drop", 64'(drop_b), 64'd0);

        for (int i = 0; i < 3; i++) begin
            dct_valid = 1'b1; dct_count = 4'd5; dct_buffer = 30'h30 + 30'(i); tick();
        end
        dct_valid = 1'b0;
        chk("pre_rst_fill", 64'(fill_a), 64'd3);

        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("arst_state", 64'(state_a), 64'd0);
        chk("arst_fill", 64'(fill_a), 64'd0);
        chk("arst_rdvalid", 64'(rd_valid_b), 64'd0);
        chk("arst_rddata", 64'(rd_data_a), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_state", 64'(state_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
